// File: rtl/instr_fetch_issue.sv
// Fetch/issue front end: fetches words over req/ack, registers them, issues field slices over valid/ready.
// Optional macro COND_EXEC_EN squashes words that fail their ARM condition check in ISSUE.
module instr_fetch_issue #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [31:0] PC_STEP     = 32'd4,
   parameter logic [3:0]  ACK_TIMEOUT = 4'd15
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] imem_addr,
   output logic        imem_req,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        issue_valid,
   input  logic        issue_ready,
   output logic [3:0]  cond_out,
   output logic [1:0]  op_out,
   output logic [5:0]  nIPUBWL_out,
   output logic [3:0]  cmd_out,
   output logic        s_out,
   output logic [1:0]  bimm_out,
   output logic [3:0]  NZCV_out,
   input  logic [3:0]  alu_flags_in,
   input  logic        flags_we_in,
   input  logic        branch_taken_in,
   input  logic [31:0] branch_target_in,
   output logic        fetch_err
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, ISSUE} state_t;

   state_t      state, state_nxt;
   logic [31:0] pc;
   logic [31:0] ir;
   logic [3:0]  nzcv;
   logic [3:0]  ack_cnt;
   logic        latch_ir;
   logic        handshake;
   logic        squash;
   logic        unused_ir_bits;

`ifdef COND_EXEC_EN
   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v;
      {n, z, c, v} = f;
      case (cond)
         4'h0: cond_pass = z;
         4'h1: cond_pass = !z;
         4'h2: cond_pass = c;
         4'h3: cond_pass = !c;
         4'h4: cond_pass = n;
         4'h5: cond_pass = !n;
         4'h6: cond_pass = v;
         4'h7: cond_pass = !v;
         4'h8: cond_pass = c && !z;
         4'h9: cond_pass = !c || z;
         4'hA: cond_pass = (n == v);
         4'hB: cond_pass = (n != v);
         4'hC: cond_pass = !z && (n == v);
         4'hD: cond_pass = z || (n != v);
         4'hE: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   endfunction
`endif

   always_comb begin
      state_nxt   = state;
      imem_req    = 1'b0;
      issue_valid = 1'b0;
      fetch_err   = 1'b0;
      latch_ir    = 1'b0;
      handshake   = 1'b0;
      squash      = 1'b0;
      case (state)
         IDLE: state_nxt = REQ;
         REQ: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               latch_ir  = 1'b1;
               state_nxt = ISSUE;
            end else begin
               state_nxt = WAIT;
            end
         end
         WAIT: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               latch_ir  = 1'b1;
               state_nxt = ISSUE;
            end else if (ack_cnt == ACK_TIMEOUT - 4'd1) begin
               // Last allowed WAIT cycle: flag the timeout and retry the same PC.
               fetch_err = 1'b1;
               state_nxt = REQ;
            end
         end
         ISSUE: begin
`ifdef COND_EXEC_EN
            if (!cond_pass(ir[31:28], nzcv)) begin
               squash    = 1'b1;
               state_nxt = REQ;
            end else begin
               issue_valid = 1'b1;
               if (issue_ready) begin
                  handshake = 1'b1;
                  state_nxt = REQ;
               end
            end
`else
            issue_valid = 1'b1;
            if (issue_ready) begin
               handshake = 1'b1;
               state_nxt = REQ;
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         ir      <= 32'h0;
         nzcv    <= 4'h0;
         ack_cnt <= 4'h0;
      end else begin
         state   <= state_nxt;
         ack_cnt <= (state == WAIT) ? ack_cnt + 4'd1 : 4'd0;
         if (latch_ir)
            ir <= imem_rdata;
         if (handshake) begin
            pc <= branch_taken_in ? branch_target_in : pc + PC_STEP;
            if (flags_we_in)
               nzcv <= alu_flags_in;
         end else if (squash) begin
            pc <= pc + PC_STEP;
         end
      end
   end

   assign imem_addr      = pc;
   assign cond_out       = ir[31:28];
   assign op_out         = ir[27:26];
   assign nIPUBWL_out    = ir[25:20];
   assign cmd_out        = ir[24:21];
   assign s_out          = ir[20];
   assign bimm_out       = ir[25:24];
   assign NZCV_out       = nzcv;
   assign unused_ir_bits = ^ir[19:0];

endmodule
